// File: rtl/board_pkg.sv
// Shared types and constants for the 2048 board move engine.
// Direction codes, FSM states and the line-to-cell index mapping.
package board_pkg;

   localparam int NUM_CELLS = 16;
   localparam int LINE_CELLS = 4;
   localparam int MAX_EXP = 11;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LINE,
      S_CHECK,
      S_SPAWN,
      S_INIT,
      S_EVAL
   } state_e;

   // Cell k of line ln, where k=0 sits on the edge the move slides toward.
   function automatic logic [3:0] cell_idx(
      input dir_e       d,
      input logic [1:0] ln,
      input logic [1:0] k
   );
      logic [1:0] rk;
      rk = 2'd3 - k;
      cell_idx = {ln, k};
      unique case (d)
         DIR_LEFT:  cell_idx = {ln, k};
         DIR_RIGHT: cell_idx = {ln, rk};
         DIR_UP:    cell_idx = {k, ln};
         DIR_DOWN:  cell_idx = {rk, ln};
         default:   ;
      endcase
   endfunction

endpackage

// File: rtl/board_move_engine_if.sv
// Command bus of the move engine: move request handshake and board preload.
// The engine owns move_ready; the controller drives everything else.
interface board_move_engine_if
   import board_pkg::*;
#(
   parameter int NUM_WIDTH = 4
);
   logic                              move_valid;
   logic [1:0]                        move_dir;
   logic                              move_ready;
   logic                              load_valid;
   logic [0:NUM_WIDTH*NUM_CELLS-1]    load_board;

   modport master (
      output move_valid, move_dir, load_valid, load_board,
      input  move_ready
   );

   modport slave (
      input  move_valid, move_dir, load_valid, load_board,
      output move_ready
   );
endinterface

// File: rtl/board_move_engine_line_merge4.sv
// Combinational 2048 slide/merge of one 4-cell line toward a0.
// Single merge pass: a merged result cannot merge again in the same move.
module line_merge4
   import board_pkg::*;
#(
   parameter int NUM_WIDTH = 4,
   parameter int MAX_EXP   = board_pkg::MAX_EXP
) (
   input  logic [NUM_WIDTH-1:0] a0,
   input  logic [NUM_WIDTH-1:0] a1,
   input  logic [NUM_WIDTH-1:0] a2,
   input  logic [NUM_WIDTH-1:0] a3,
   output logic [NUM_WIDTH-1:0] b0,
   output logic [NUM_WIDTH-1:0] b1,
   output logic [NUM_WIDTH-1:0] b2,
   output logic [NUM_WIDTH-1:0] b3,
   output logic                 changed,
   output logic [19:0]          score_inc
);
   typedef logic [NUM_WIDTH-1:0] cell_t;
   localparam cell_t CAP = cell_t'(MAX_EXP);

   cell_t      in_c [LINE_CELLS];
   cell_t      cmp  [LINE_CELLS];
   cell_t      mrg  [LINE_CELLS];
   cell_t      out_c[LINE_CELLS];
   logic [2:0] n;

   always_comb begin
      in_c = '{a0, a1, a2, a3};
      cmp = '{default: '0};
      out_c = '{default: '0};
      score_inc = '0;
      n = '0;
      for (int i = 0; i < LINE_CELLS; i++) begin
         if (in_c[i] != '0) begin
            cmp[n[1:0]] = in_c[i];
            n = n + 3'd1;
         end
      end
      mrg = cmp;
      for (int i = 0; i < LINE_CELLS - 1; i++) begin
         if (mrg[i] != '0 && mrg[i] == mrg[i+1] && mrg[i] < CAP) begin
            mrg[i] = mrg[i] + cell_t'(1);
            mrg[i+1] = '0;
            score_inc = score_inc + (20'd1 << mrg[i]);
         end
      end
      n = '0;
      for (int i = 0; i < LINE_CELLS; i++) begin
         if (mrg[i] != '0) begin
            out_c[n[1:0]] = mrg[i];
            n = n + 3'd1;
         end
      end
   end

   assign b0 = out_c[0];
   assign b1 = out_c[1];
   assign b2 = out_c[2];
   assign b3 = out_c[3];
   assign changed = {b0, b1, b2, b3} != {a0, a1, a2, a3};

endmodule

// File: rtl/board_move_engine.sv
// 2048 game-logic stage: runs moves line by line on a working board,
// spawns tiles, and commits board/score to the renderers only at EVAL.
module board_move_engine
   import board_pkg::*;
#(
   parameter int          NUM_WIDTH = 4,
   parameter int          MAX_EXP   = board_pkg::MAX_EXP,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                           dclk,
   input  logic                           clr_n,
   input  logic                           start,
   board_move_engine_if.slave             cmd,
   output logic [0:NUM_WIDTH*NUM_CELLS-1] board_state,
   output logic [19:0]                    score,
   output logic                           won,
   output logic                           lost,
   output logic                           busy
);
   typedef logic [NUM_WIDTH-1:0] cell_t;
   localparam cell_t CAP = cell_t'(MAX_EXP);
   localparam int BW = NUM_WIDTH * NUM_CELLS;

   state_e      state;
   dir_e        dir;
   logic [1:0]  line;
   logic        chg;
   logic [3:0]  ptr;
   logic        second;
   logic [19:0] wscore;
   logic [15:0] lfsr;
   cell_t       wb [NUM_CELLS];

   logic [3:0]  li [LINE_CELLS];
   cell_t       a  [LINE_CELLS];
   cell_t       b  [LINE_CELLS];
   logic        lchg;
   logic [19:0] linc;
   logic [20:0] ssum;
   logic [19:0] sat;
   logic [0:BW-1] wb_flat;
   logic        any_max, any_zero, any_pair;
   logic        ready;
   cell_t       tile;

   always_comb begin
      for (int k = 0; k < LINE_CELLS; k++) begin
         li[k] = cell_idx(dir, line, 2'(k));
         a[k] = wb[li[k]];
      end
   end

   line_merge4 #(
      .NUM_WIDTH(NUM_WIDTH),
      .MAX_EXP  (MAX_EXP)
   ) u_merge (
      .a0       (a[0]),
      .a1       (a[1]),
      .a2       (a[2]),
      .a3       (a[3]),
      .b0       (b[0]),
      .b1       (b[1]),
      .b2       (b[2]),
      .b3       (b[3]),
      .changed  (lchg),
      .score_inc(linc)
   );

   assign ssum = {1'b0, wscore} + {1'b0, linc};
   assign sat = ssum[20] ? 20'hFFFFF : ssum[19:0];
   assign tile = (lfsr[7:5] == 3'd0) ? cell_t'(2) : cell_t'(1);

   always_comb begin
      wb_flat = '0;
      any_max = 1'b0;
      any_zero = 1'b0;
      any_pair = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         wb_flat[i*NUM_WIDTH +: NUM_WIDTH] = wb[i];
         if (wb[i] == CAP) any_max = 1'b1;
         if (wb[i] == '0) any_zero = 1'b1;
      end
      // Capped tiles never merge, so an equal pair of them is not a move.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (wb[r*4+c] == wb[r*4+c+1] && wb[r*4+c] < CAP)
               any_pair = 1'b1;
            if (wb[c*4+r] == wb[c*4+r+4] && wb[c*4+r] < CAP)
               any_pair = 1'b1;
         end
      end
   end

   assign ready = (state == S_IDLE) && !lost;
   assign cmd.move_ready = ready;
   assign busy = (state != S_IDLE);

   always_ff @(posedge dclk or negedge clr_n) begin
      if (!clr_n) begin
         state <= S_IDLE;
         dir <= DIR_UP;
         line <= '0;
         chg <= 1'b0;
         ptr <= '0;
         second <= 1'b0;
         wscore <= '0;
         score <= '0;
         won <= 1'b0;
         lost <= 1'b0;
         board_state <= '0;
         lfsr <= LFSR_SEED;
         for (int i = 0; i < NUM_CELLS; i++) wb[i] <= '0;
      end else begin
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0);
         if (start) begin
            state <= S_INIT;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (cmd.load_valid) begin
                     for (int i = 0; i < NUM_CELLS; i++)
                        wb[i] <= cmd.load_board[i*NUM_WIDTH +: NUM_WIDTH];
                     wscore <= '0;
                     won <= 1'b0;
                     lost <= 1'b0;
                     state <= S_EVAL;
                  end else if (cmd.move_valid && ready) begin
                     dir <= dir_e'(cmd.move_dir);
                     for (int i = 0; i < NUM_CELLS; i++)
                        wb[i] <= board_state[i*NUM_WIDTH +: NUM_WIDTH];
                     wscore <= score;
                     line <= '0;
                     chg <= 1'b0;
                     state <= S_LINE;
                  end
               end
               S_LINE: begin
                  for (int k = 0; k < LINE_CELLS; k++) wb[li[k]] <= b[k];
                  chg <= chg | lchg;
                  wscore <= sat;
                  line <= line + 2'd1;
                  if (line == 2'd3) state <= S_CHECK;
               end
               S_CHECK: begin
                  ptr <= lfsr[3:0];
                  second <= 1'b0;
                  state <= chg ? S_SPAWN : S_IDLE;
               end
               S_SPAWN: begin
                  if (wb[ptr] == '0) begin
                     wb[ptr] <= tile;
                     if (second) begin
                        ptr <= lfsr[3:0];
                        second <= 1'b0;
                     end else begin
                        state <= S_EVAL;
                     end
                  end else begin
                     ptr <= ptr + 4'd1;
                  end
               end
               S_INIT: begin
                  for (int i = 0; i < NUM_CELLS; i++) wb[i] <= '0;
                  wscore <= '0;
                  won <= 1'b0;
                  lost <= 1'b0;
                  ptr <= lfsr[3:0];
                  second <= 1'b1;
                  state <= S_SPAWN;
               end
               S_EVAL: begin
                  board_state <= wb_flat;
                  score <= wscore;
                  won <= won | any_max;
                  lost <= ~any_zero & ~any_pair;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/board_move_engine.md
Name: board_move_engine

Overview:
- Game-logic stage directly upstream of the VGA tile renderers.
- Holds the 4x4 2048 board and executes slide/merge moves on direction commands, one line per cycle.
- Spawns a pseudo-random tile after every board-changing move, then evaluates win/loss.
- Publishes a stable board_state bus in the renderers' encoding. The bus only changes at commit, so the combinational renderers never see a half-processed move.

Parameters:
- NUM_WIDTH, 4, bits per cell. 0 = blank; k = tile 2^k; renderer asset index = k-1.
- MAX_EXP, 11, largest tile exponent (2048); two MAX_EXP tiles never merge.
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset; must be nonzero.

Ports:
- dclk  in  1  system clock; all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin a new game; accepted in any state.
- move_valid  in  1  move request.
- move_dir  in  2  0=up, 1=down, 2=left, 3=right.
- move_ready  out  1  high only in IDLE with lost=0.
- load_valid  in  1  test/debug preload, honoured only in IDLE.
- load_board  in  [0:NUM_WIDTH*16-1]  preload image, same layout as board_state.
- board_state  out  [0:NUM_WIDTH*16-1]  cell idx = row*4+col at bits [idx*NUM_WIDTH +: NUM_WIDTH]; cell 0 = top-left.
- score  out  20  accumulated score.
- won  out  1  sticky: some cell == MAX_EXP.
- lost  out  1  sticky: no legal move remains.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, clr_n=0):
  - board_state=0, working board=0, score=0, won=0, lost=0.
  - state=IDLE, LFSR=LFSR_SEED.
  - An in-progress move is discarded; nothing is committed.
- LFSR: 16-bit Galois, feedback mask 16'hB400, advances every cycle in every state.
- States and transitions:
  - IDLE:
    - start: go to INIT. start has priority over everything else in every state, including mid-move (abort).
    - else load_valid: copy load_board to the working board, score=0, won=0, lost=0, go to EVAL. load_valid has priority over move.
    - else move_valid && move_ready: latch move_dir, copy board_state to the working board, line=0, go to LINE.
  - LINE (4 cycles, line 0..3): extract line `line` as cells a0..a3, with a0 at the destination edge:
    - left: row r, cols 0..3.
    - right: row r, cols 3..0.
    - up: col c, rows 0..3.
    - down: col c, rows 3..0.
    - Apply line merge, write back, OR the changed flag into the move-changed register, add the score increment.
    - After line 3, go to CHECK.
  - CHECK (1 cycle): changed=1 goes to SPAWN; changed=0 goes to IDLE. board_state and score are untouched in the no-change case.
  - SPAWN:
    - On entry, ptr = LFSR[3:0].
    - Each cycle: if the working cell ptr is 0, write the tile and go to EVAL; else ptr = ptr+1 mod 16.
    - Tile value is 2 if LFSR[7:5]==0, else 1.
    - Takes at most 16 cycles. A changed move guarantees an empty cell exists.
  - INIT:
    - Clear the working board, score=0, won=0, lost=0.
    - Run the SPAWN search twice (second spawn into a different empty cell), then go to EVAL.
  - EVAL (1 cycle), then IDLE:
    - Commit the working board to board_state; commit score.
    - won |= any cell == MAX_EXP.
    - lost = no zero cell and no horizontally or vertically adjacent equal pair. MAX_EXP pairs do not count as mergeable.
- Line merge (combinational):
  - Compact nonzero cells toward a0.
  - Scan pairs (0,1), (1,2), (2,3) once, left to right. Equal nonzero values below MAX_EXP merge into the lower index as value+1; the upper cell is cleared and that cell is consumed for the rest of the scan.
  - Compact again.
  - Score increment = sum of 2^(value+1) over all merges in the line.
  - changed = output != input.
- Score: 20-bit saturating at 20'hFFFFF.
- Latency for a changed move accepted at cycle T: LINE T+1..T+4, CHECK T+5, SPAWN T+6..T+21 (worst case), EVAL, then move_ready high the cycle after EVAL.
- Latency for an unchanged move accepted at cycle T: move_ready high again at T+6.
- move_valid outside IDLE is ignored, not queued.

Decomposition:
- Package board_pkg contains:
  - direction codes DIR_UP/DOWN/LEFT/RIGHT;
  - state encoding (IDLE, LINE, CHECK, SPAWN, INIT, EVAL);
  - NUM_CELLS=16, MAX_EXP, LFSR mask;
  - cell index helper constants.
- One sub-module, line_merge4:
  - purely combinational;
  - inputs a0..a3;
  - outputs b0..b3, changed, score_inc.
  - Verified standalone.

Test Plan:
- Reset: hold clr_n=0 mid-move, release -> board_state=0, score=0, won=lost=0, busy=0, move_ready=1.
- Merge left: load row0=[1,1,2,2], rest 0; move left -> row0=[2,3,*,*] with the cells outside row0's first two positions zero except exactly one new cell of value 1 or 2; score=12.
- Merge right: load row0=[1,1,1,1]; move right -> row0 cols 2,3 = [2,2]; exactly one spawned cell elsewhere; score=8.
- No change: load row0=[1,2,3,4], rest 0; move left -> board_state unchanged, score=0, move_ready high at T+6, no spawn.
- Cap and win: load cells 0,1 = 11,11, rest 0 -> won=1 after EVAL; move left -> no merge, board unchanged, score=0.
- Loss and restart:
  - Load a full checkerboard alternating 1/2 -> lost=1, move_ready=0; move_valid is ignored.
  - Pulse start -> exactly 2 nonzero cells, each 1 or 2; lost=0, score=0.
